twenty_bit_bitwise_and_unit: RTL and testbench
==============================================

Name: twenty_bit_bitwise_and_unit

Overview:
- Registered 20-bit bitwise AND stage for the SuperSpeedCPU datapath. Used by the ALU logic-op path.
- Computes s = i0 & i1 and holds the result in an output register.
- Uses a single-entry valid/ready handshake and produces zero/negative status flags for the flag unit.

Parameters:
- WIDTH, 20, operand and result width in bits; only 20 is verified.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- i0  input  WIDTH  operand A.
- i1  input  WIDTH  operand B.
- in_valid  input  1  operands are valid this cycle.
- in_ready  output  1  stage can accept operands this cycle.
- s  output  WIDTH  registered result, i0 & i1.
- out_valid  output  1  s and flags hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- zero  output  1  result equals 0 (see Optional Feature).
- neg  output  1  result bit WIDTH-1 (see Optional Feature).

Behaviour:
- Reset: on a rising clk edge with rst=1, out_valid=0, s=0, zero=0 and neg=0. rst takes priority over every other event. A reset mid-transfer discards the held result.
- in_ready = !out_valid || out_ready. It is purely combinational and does not depend on in_valid.
- Accept: when in_valid && in_ready at a rising edge:
  - s <= i0 & i1, each bit s[k] = i0[k] & i1[k], with no carries or cross-bit effects;
  - out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid=1. Back-to-back throughput is 1 result per cycle while out_ready=1.
- Drain: when out_valid && out_ready && !(in_valid && in_ready), out_valid <= 0. s and the flags keep their last values; they are don't-care while out_valid=0.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and out_valid stays 1.
- Stall: while out_valid=1 and out_ready=0:
  - s, zero and neg hold stable;
  - in_ready=0;
  - i0 and i1 are ignored.
- in_valid=0: no register update except the drain rule above.
- Operands are never registered; only the result is.
- No X propagation from i0/i1 into the registers when no accept occurs.

Optional Feature:
- Macro BWAND_FLAGS_EN.
- Defined:
  - zero is registered alongside s as (i0 & i1) == 0;
  - neg is registered as (i0 & i1)[WIDTH-1];
  - both update only on accept and reset to 0.
- Undefined: zero and neg are tied to constant 0, no flag registers are inferred, and the ports remain present.

Decomposition:
- Shared package twenty_bit_bitwise_and_pkg:
  - localparam BWAND_WIDTH = 20;
  - typedef logic [BWAND_WIDTH-1:0] word_t;
  - typedef struct packed {logic zero; logic neg;} bwand_flags_t.
- Sub-module twenty_bit_and_core: purely combinational. It takes a, b (word_t) and outputs y = a & b, plus combinational zero/neg.
- The unit instantiates the core and adds the handshake and output register.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, s=0, zero=0, neg=0. in_ready=1 once the bench is out of reset with out_ready=1.
- Zero operands: i0=0x00000, i1=0x00000, in_valid=1, out_ready=1 -> next cycle s=0x00000, out_valid=1, zero=1, neg=0 (flags per BWAND_FLAGS_EN).
- Masked to zero: i0=0x0005F, i1=0x00000 -> s=0x00000, zero=1, neg=0. Then i0=0xC0003, i1=0xC0003 back-to-back -> s=0xC0003 the following cycle, zero=0, neg=1.
- All ones: i0=0xFFFFF, i1=0xFFFFF -> s=0xFFFFF, zero=0, neg=1. Then i0=0xAAAAA, i1=0x55555 -> s=0x00000, zero=1.
- Backpressure:
  - load 0xC0003&0xC0003, then hold out_ready=0 for 3 cycles while presenting i0=0xFFFFF, i1=0xFFFFF -> s stays 0xC0003 and in_ready=0;
  - raise out_ready together with in_valid -> the 0xFFFFF result appears next cycle with out_valid still 1.
- Reset mid-stall: with out_valid=1 and out_ready=0, assert rst for 1 cycle -> out_valid=0 and s=0 on the next edge, in_ready=1.

Source files
------------

// File: rtl/twenty_bit_bitwise_and_pkg.sv
// Shared types for the registered 20-bit bitwise AND stage.
package twenty_bit_bitwise_and_pkg;

    localparam int BWAND_WIDTH = 20;

    typedef logic [BWAND_WIDTH-1:0] word_t;

    typedef struct packed {
        logic zero;
        logic neg;
    } bwand_flags_t;

endpackage

// File: rtl/twenty_bit_and_core.sv
// Combinational 20-bit AND with result status flags.
// Flag outputs exist only when BWAND_FLAGS_EN is defined.
module twenty_bit_and_core
    import twenty_bit_bitwise_and_pkg::*;
(
    input  word_t        a,
    input  word_t        b,
`ifdef BWAND_FLAGS_EN
    output bwand_flags_t flags,
`endif
    output word_t        y
);

    // Bit-independent AND; no cross-bit logic.
    assign y = a & b;

`ifdef BWAND_FLAGS_EN
    // Status derived from the combinational result so it registers with s.
    assign flags.zero = (y == '0);
    assign flags.neg  = y[BWAND_WIDTH-1];
`endif

endmodule

// File: rtl/twenty_bit_bitwise_and_unit.sv
// Registered 20-bit bitwise AND stage with single-entry valid/ready output.
// Optional macro BWAND_FLAGS_EN: registers zero/neg status alongside s;
// without it zero and neg are tied low and no flag registers exist.
module twenty_bit_bitwise_and_unit
    import twenty_bit_bitwise_and_pkg::*;
#(
    parameter int WIDTH = BWAND_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic             neg
);

    word_t core_y;
    word_t s_d, s_q;
    logic  out_valid_d, out_valid_q;
    logic  accept;

`ifdef BWAND_FLAGS_EN
    bwand_flags_t core_flags;
    bwand_flags_t flags_d, flags_q;
`endif

    twenty_bit_and_core u_core (
        .a     (i0),
        .b     (i1),
`ifdef BWAND_FLAGS_EN
        .flags (core_flags),
`endif
        .y     (core_y)
    );

    // Free slot when empty or when the held result leaves this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Next-state: accept loads a new result, otherwise a consumed result drains.
    always_comb begin
        s_d         = s_q;
        out_valid_d = out_valid_q;
`ifdef BWAND_FLAGS_EN
        flags_d     = flags_q;
`endif
        if (accept) begin
            s_d         = core_y;
            out_valid_d = 1'b1;
`ifdef BWAND_FLAGS_EN
            flags_d     = core_flags;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            out_valid_q <= 1'b0;
`ifdef BWAND_FLAGS_EN
            flags_q     <= '0;
`endif
        end else begin
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
`ifdef BWAND_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    assign s         = s_q;
    assign out_valid = out_valid_q;

`ifdef BWAND_FLAGS_EN
    assign zero = flags_q.zero;
    assign neg  = flags_q.neg;
`else
    assign zero = 1'b0;
    assign neg  = 1'b0;
`endif

endmodule

// File: tb/tb_twenty_bit_bitwise_and_unit.sv
// Scoreboard bench for twenty_bit_bitwise_and_unit.
module tb_twenty_bit_bitwise_and_unit;

`ifdef BWAND_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [19:0] s;
        logic        zero;
        logic        neg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] i0, i1;
    logic        in_valid, in_ready;
    logic [19:0] s;
    logic        out_valid, out_ready;
    logic        zero, neg;

    int compared   = 0;
    int mismatched = 0;
    exp_t sb_q[$];

    twenty_bit_bitwise_and_unit dut (
        .clk       (clk),
        .rst       (rst),
        .i0        (i0),
        .i1        (i1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: i0, i1, s, zero, neg (flags as if BWAND_FLAGS_EN)
    logic [19:0] v_i0 [6] = '{20'h00000, 20'h0005F, 20'hC0003, 20'hFFFFF, 20'hAAAAA, 20'h12345};
    logic [19:0] v_i1 [6] = '{20'h00000, 20'h00000, 20'hC0003, 20'hFFFFF, 20'h55555, 20'h0F0F0};
    logic [19:0] v_s  [6] = '{20'h00000, 20'h00000, 20'hC0003, 20'hFFFFF, 20'h00000, 20'h02040};
    logic        v_z  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        v_n  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    task automatic push_exp(input logic [19:0] es, input logic ez, input logic en);
        exp_t e;
        e.s    = es;
        e.zero = FLAGS_EN ? ez : 1'b0;
        e.neg  = FLAGS_EN ? en : 1'b0;
        sb_q.push_back(e);
    endtask

    // Monitor: every completed output handshake is checked against the queue.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sb_unexpected: got s=0x%0h expected no output", s);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_s", 32'(s), 32'(e.s));
                check("sb_zero", 32'(zero), 32'(e.zero));
                check("sb_neg", 32'(neg), 32'(e.neg));
            end
        end
    end

    // Watchdog keeps the run bounded.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        i0 = 20'hFFFFF; i1 = 20'hFFFFF;
        cyc(); cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_neg", 32'(neg), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back directed vectors
        for (int k = 0; k < 6; k++) begin
            i0 = v_i0[k]; i1 = v_i1[k]; in_valid = 1'b1;
            push_exp(v_s[k], v_z[k], v_n[k]);
            cyc();
            check("b2b_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        cyc();
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure
        i0 = 20'hC0003; i1 = 20'hC0003; in_valid = 1'b1;
        push_exp(20'hC0003, 1'b0, 1'b1);
        cyc();
        out_ready = 1'b0; i0 = 20'hFFFFF; i1 = 20'hFFFFF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            cyc();
            check("stall_s", 32'(s), 32'hC0003);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        push_exp(20'hFFFFF, 1'b0, 1'b1);
        cyc();
        check("release_out_valid", 32'(out_valid), 32'd1);
        check("release_s", 32'(s), 32'hFFFFF);
        in_valid = 1'b0;
        cyc();
        check("release_drain", 32'(out_valid), 32'd0);

        // Reset mid-stall discards the held result (not queued)
        i0 = 20'h0F0F0; i1 = 20'hFFFFF; in_valid = 1'b1; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("midstall_out_valid", 32'(out_valid), 32'd1);
        check("midstall_s", 32'(s), 32'h0F0F0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        cyc(); cyc();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
